// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide unit: latches operands on start, holds Busy for a fixed
// per-operation latency, then commits the product/quotient into HI/LO.
module e_mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_MDUA,
    input  logic [31:0] E_MDUB,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_MDUStart,
    output logic [31:0] E_MDURe,
    output logic        E_MDUBusy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned OW = 4;

    localparam logic [OW-1:0] OP_MULT  = OW'(1);
    localparam logic [OW-1:0] OP_MULTU = OW'(2);
    localparam logic [OW-1:0] OP_DIV   = OW'(3);
    localparam logic [OW-1:0] OP_DIVU  = OW'(4);
    localparam logic [OW-1:0] OP_MFHI  = OW'(5);
    localparam logic [OW-1:0] OP_MFLO  = OW'(6);
    localparam logic [OW-1:0] OP_MTHI  = OW'(7);
    localparam logic [OW-1:0] OP_MTLO  = OW'(8);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [W-1:0]  a_q, b_q;
    logic [OW-1:0] op_q;

    logic          is_arith;
    logic          accept;
    logic          commit;
    logic          mthi_we, mtlo_we;

    logic [2*W-1:0] prod_s, prod_u;
    logic [W-1:0]   a_mag, b_mag, b_div, q_mag, r_mag;
    logic [W-1:0]   res_hi, res_lo;
    logic           res_wr;

    assign is_arith = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (E_MDUStart && is_arith) state_nx = S_RUN;
            S_RUN:  if (cnt == '0)              state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Control strobes and combinational read port
    always_comb begin
        accept  = 1'b0;
        commit  = 1'b0;
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        E_MDURe = '0;
        case (state)
            S_IDLE: begin
                accept  = E_MDUStart && is_arith;
                mthi_we = (E_MDUOp == OP_MTHI);
                mtlo_we = (E_MDUOp == OP_MTLO);
            end
            S_RUN:  commit = (cnt == '0);
            default: ;
        endcase
        if (E_MDUOp == OP_MFHI) begin
            E_MDURe = E_HI;
        end else if (E_MDUOp == OP_MFLO) begin
            E_MDURe = E_LO;
        end
    end

    assign E_MDUBusy = (state == S_RUN);

    // Arithmetic from latched operands; sign-extended 64-bit multiply yields the signed product
    always_comb begin
        prod_s = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
        prod_u = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

        a_mag = a_q;
        b_mag = b_q;
        if (op_q == OP_DIV) begin
            if (a_q[W-1]) a_mag = ~a_q + W'(1);
            if (b_q[W-1]) b_mag = ~b_q + W'(1);
        end
        b_div = (b_mag == '0) ? W'(1) : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;

        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        case (op_q)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            OP_DIV: begin
                // Quotient truncates toward zero; remainder follows the dividend's sign
                res_lo = (a_q[W-1] ^ b_q[W-1]) ? (~q_mag + W'(1)) : q_mag;
                res_hi = a_q[W-1] ? (~r_mag + W'(1)) : r_mag;
                res_wr = (b_q != '0);
            end
            OP_DIVU: begin
                res_lo = q_mag;
                res_hi = r_mag;
                res_wr = (b_q != '0);
            end
            default: ;
        endcase
    end

    // Operand latches, latency counter and HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            cnt  <= '0;
            E_HI <= '0;
            E_LO <= '0;
        end else begin
            if (accept) begin
                a_q  <= E_MDUA;
                b_q  <= E_MDUB;
                op_q <= E_MDUOp;
                cnt  <= (E_MDUOp <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;
            end else if ((state == S_RUN) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end

            if (commit && res_wr) begin
                E_HI <= res_hi;
                E_LO <= res_lo;
            end else begin
                if (mthi_we) E_HI <= E_MDUA;
                if (mtlo_we) E_LO <= E_MDUA;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level HI/LO model.
module tb_e_mdu_ctrl;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        start;
    logic [31:0] re, hi, lo;
    logic        busy;

    always #5 clk = ~clk;

    e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDUA     (a),
        .E_MDUB     (b),
        .E_MDUOp    (op),
        .E_MDUStart (start),
        .E_MDURe    (re),
        .E_MDUBusy  (busy),
        .E_HI       (hi),
        .E_LO       (lo)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: architectural HI/LO plus a pending result and cycles remaining
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_wr;
    int          left;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_wr = 0; left = 0;
    endfunction

    function automatic void model_edge();
        longint          sa, sb;
        longint unsigned ua, ub, pu;
        longint          ps;
        if (left > 0) begin
            left--;
            if (left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start && op >= 4'd1 && op <= 4'd4) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ua = {32'd0, a};
            ub = {32'd0, b};
            p_wr = 1;
            case (op)
                4'd1: begin ps = sa * sb; {p_hi, p_lo} = 64'(ps); end
                4'd2: begin pu = ua * ub; {p_hi, p_lo} = 64'(pu); end
                4'd3: if (b == 0) p_wr = 0;
                      else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
                default: if (b == 0) p_wr = 0;
                      else begin p_lo = a / b; p_hi = a % b; end
            endcase
            left = (op <= 4'd2) ? int'(MC) : int'(DC);
        end else if (op == 4'd7) begin
            m_hi = a;
        end else if (op == 4'd8) begin
            m_lo = a;
        end
    endfunction

    // One clock cycle: drive, check read port, clock the model with the DUT, check state
    task automatic cyc(input logic [3:0] o, input logic s, input logic [31:0] av, input logic [31:0] bv);
        op = o; start = s; a = av; b = bv;
        #1;
        chk("re", re, (o == 4'd5) ? m_hi : (o == 4'd6) ? m_lo : 32'd0);
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", {31'd0, busy}, {31'd0, left > 0});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    // Issue an arithmetic op and count its busy cycles (bounded)
    task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input int exp_lat);
        int cnt = 0;
        cyc(o, 1'b1, av, bv);
        while (busy && cnt < 20) begin
            cnt++;
            cyc(4'd0, 1'b0, 32'd0, 32'd0);
        end
        chk("latency", 32'(cnt), 32'(exp_lat));
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
        case ($urandom_range(0, 3))
            0:       return sp[$urandom_range(0, 5)];
            1:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; op = '0; start = 1'b0; a = '0; b = '0;
        model_reset();
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        #13 reset = 1'b0;
        @(posedge clk); #1;

        // Reset mid-run discards the in-flight multiply
        cyc(4'd8, 1'b0, 32'h99, 32'd0);
        cyc(4'd1, 1'b1, 32'd5, 32'd7);
        cyc(4'd0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (8) cyc(4'd0, 1'b0, 32'd0, 32'd0);
        chk("no_commit_lo", lo, 32'd0);
        run_op(4'd2, 32'd3, 32'd4, MC);
        chk("multu_3x4", lo, 32'd12);

        // Multiply signed/unsigned
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, MC);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, MC);
        chk("multu_hi", hi, 32'h2);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        // Divide
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, DC);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        run_op(4'd4, 32'd7, 32'd2, DC);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, DC);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'd0);

        // Divide by zero leaves HI/LO untouched
        cyc(4'd7, 1'b0, 32'h11, 32'd0);
        cyc(4'd8, 1'b0, 32'h22, 32'd0);
        run_op(4'd3, 32'd5, 32'd0, DC);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        // Ops issued while running are ignored
        cyc(4'd8, 1'b0, 32'h55, 32'd0);
        cyc(4'd3, 1'b1, 32'd100, 32'd7);
        cyc(4'd1, 1'b1, 32'd9, 32'd9);
        cyc(4'd7, 1'b0, 32'hABCD, 32'd0);
        chk("run_mthi", hi, 32'h11);
        op = 4'd6; start = 1'b0; #1;
        chk("run_mflo", re, 32'h55);
        begin
            int guard = 0;
            while (busy && guard < 20) begin
                guard++;
                cyc(4'd6, 1'b0, 32'd0, 32'd0);
            end
        end
        chk("ign_hi", hi, 32'd2);
        chk("ign_lo", lo, 32'd14);

        // Back-to-back: start accepted on the cycle right after Busy falls
        run_op(4'd2, 32'd2, 32'd3, MC);
        chk("b2b_lo", lo, 32'd6);
        op = 4'd6; #1;
        chk("b2b_mflo", re, 32'd6);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), pick(), pick());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
